// File: rtl/bpu_ras_multi.sv
// Multi-slot fetch branch predictor: set-associative BTB with round-robin replacement,
// local-history PHT and a checkpointable speculative return-address stack.
module bpu_ras_multi #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned BTB_SETS    = 16,
  parameter int unsigned BTB_WAYS    = 2,
  parameter int unsigned TAGLEN      = 8,
  parameter int unsigned BHT_NUM     = 32,
  parameter int unsigned BHRLEN      = 6,
  parameter int unsigned RAS_DEPTH   = 8,
  localparam int unsigned SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int unsigned RAS_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [SLOT_W-1:0] pred_slot,
  output logic [31:0]       pred_target,
  output logic [RAS_W-1:0]  pred_ras_ptr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [1:0]        upd_type,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispred,
  input  logic [RAS_W-1:0]  upd_ras_ptr
);
  localparam int unsigned SET_W   = $clog2(BTB_SETS);
  localparam int unsigned WAY_W   = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
  localparam int unsigned BHT_W   = $clog2(BHT_NUM);
  localparam int unsigned PHT_NUM = 1 << BHRLEN;
  localparam logic [1:0] TYPE_COND = 2'b00;
  localparam logic [1:0] TYPE_CALL = 2'b10;
  localparam logic [1:0] TYPE_RET  = 2'b11;

  logic              r_btb_valid  [BTB_SETS][BTB_WAYS];
  logic [TAGLEN-1:0] r_btb_tag    [BTB_SETS][BTB_WAYS];
  logic [31:0]       r_btb_target [BTB_SETS][BTB_WAYS];
  logic [1:0]        r_btb_type   [BTB_SETS][BTB_WAYS];
  logic [WAY_W-1:0]  r_rr         [BTB_SETS];
  logic [BHRLEN-1:0] r_bht        [BHT_NUM];
  logic [1:0]        r_pht        [PHT_NUM];
  logic [31:0]       r_ras        [RAS_DEPTH];
  logic [RAS_W-1:0]  r_ras_ptr;

  logic [31:0]       w_pc      [FETCH_WIDTH];
  logic [BHRLEN-1:0] w_pht_idx [FETCH_WIDTH];
  logic              w_hit     [FETCH_WIDTH];
  logic [1:0]        w_typ     [FETCH_WIDTH];
  logic [31:0]       w_tgt     [FETCH_WIDTH];
  logic              w_tk      [FETCH_WIDTH];
  logic              w_win;
  logic [SLOT_W-1:0] w_win_slot;
  logic [1:0]        w_win_type;
  logic [31:0]       w_win_pc;
  logic [31:0]       w_win_btb_tgt;
  logic [31:0]       w_win_target;

  // Lookup against pre-update state; the lowest taken slot wins.
  always_comb begin
    w_win         = 1'b0;
    w_win_slot    = '0;
    w_win_type    = TYPE_COND;
    w_win_pc      = '0;
    w_win_btb_tgt = '0;
    for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
      w_pc[k]      = fetch_pc + 32'(4 * k);
      w_pht_idx[k] = r_bht[w_pc[k][2 +: BHT_W]] ^ w_pc[k][2 +: BHRLEN];
      w_hit[k]     = 1'b0;
      w_typ[k]     = TYPE_COND;
      w_tgt[k]     = '0;
      for (int w = 0; w < int'(BTB_WAYS); w++) begin
        if (r_btb_valid[w_pc[k][2 +: SET_W]][w] &&
            (r_btb_tag[w_pc[k][2 +: SET_W]][w] == w_pc[k][2+SET_W +: TAGLEN])) begin
          w_hit[k] = 1'b1;
          w_typ[k] = r_btb_type[w_pc[k][2 +: SET_W]][w];
          w_tgt[k] = r_btb_target[w_pc[k][2 +: SET_W]][w];
        end
      end
      w_tk[k] = w_hit[k] && ((w_typ[k] != TYPE_COND) || r_pht[w_pht_idx[k]][1]);
      if (!w_win && w_tk[k]) begin
        w_win         = 1'b1;
        w_win_slot    = SLOT_W'(k);
        w_win_type    = w_typ[k];
        w_win_pc      = w_pc[k];
        w_win_btb_tgt = w_tgt[k];
      end
    end
  end

  assign w_win_target = (w_win_type == TYPE_RET) ? r_ras[r_ras_ptr - RAS_W'(1)] : w_win_btb_tgt;

  logic [SET_W-1:0]  w_upd_set;
  logic [TAGLEN-1:0] w_upd_tag;
  logic [BHT_W-1:0]  w_upd_bht_idx;
  logic [BHRLEN-1:0] w_upd_pht_idx;
  logic              w_upd_hit;
  logic [WAY_W-1:0]  w_upd_hit_way;
  logic              w_upd_free;
  logic [WAY_W-1:0]  w_upd_free_way;
  logic              w_upd_repl;
  logic [WAY_W-1:0]  w_upd_way;

  assign w_upd_set     = upd_pc[2 +: SET_W];
  assign w_upd_tag     = upd_pc[2+SET_W +: TAGLEN];
  assign w_upd_bht_idx = upd_pc[2 +: BHT_W];
  assign w_upd_pht_idx = r_bht[w_upd_bht_idx] ^ upd_pc[2 +: BHRLEN];

  // Victim choice: tag hit, else lowest invalid way, else round-robin way.
  always_comb begin
    w_upd_hit      = 1'b0;
    w_upd_hit_way  = '0;
    w_upd_free     = 1'b0;
    w_upd_free_way = '0;
    for (int w = int'(BTB_WAYS) - 1; w >= 0; w--) begin
      if (r_btb_valid[w_upd_set][w] && (r_btb_tag[w_upd_set][w] == w_upd_tag)) begin
        w_upd_hit     = 1'b1;
        w_upd_hit_way = WAY_W'(w);
      end
      if (!r_btb_valid[w_upd_set][w]) begin
        w_upd_free     = 1'b1;
        w_upd_free_way = WAY_W'(w);
      end
    end
    w_upd_repl = !w_upd_hit && !w_upd_free;
    w_upd_way  = w_upd_hit ? w_upd_hit_way : (w_upd_free ? w_upd_free_way : r_rr[w_upd_set]);
  end

  logic [RAS_W-1:0] w_ras_ptr_nxt;
  logic             w_ras_we;
  logic [RAS_W-1:0] w_ras_widx;
  logic [31:0]      w_ras_wdata;

  // A mispredict restore takes priority over the speculative push/pop of this cycle's fetch.
  always_comb begin
    w_ras_ptr_nxt = r_ras_ptr;
    w_ras_we      = 1'b0;
    w_ras_widx    = r_ras_ptr;
    w_ras_wdata   = '0;
    if (upd_valid && upd_mispred) begin
      w_ras_ptr_nxt = upd_ras_ptr;
      if (upd_type == TYPE_CALL) begin
        w_ras_we      = 1'b1;
        w_ras_widx    = upd_ras_ptr;
        w_ras_wdata   = upd_pc + 32'd4;
        w_ras_ptr_nxt = upd_ras_ptr + RAS_W'(1);
      end else if (upd_type == TYPE_RET) begin
        w_ras_ptr_nxt = upd_ras_ptr - RAS_W'(1);
      end
    end else if (fetch_valid && w_win) begin
      if (w_win_type == TYPE_CALL) begin
        w_ras_we      = 1'b1;
        w_ras_wdata   = w_win_pc + 32'd4;
        w_ras_ptr_nxt = r_ras_ptr + RAS_W'(1);
      end else if (w_win_type == TYPE_RET) begin
        w_ras_ptr_nxt = r_ras_ptr - RAS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_slot    <= '0;
      pred_target  <= '0;
      pred_ras_ptr <= '0;
      r_ras_ptr    <= '0;
      for (int s = 0; s < int'(BTB_SETS); s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < int'(BTB_WAYS); w++) begin
          r_btb_valid[s][w]  <= 1'b0;
          r_btb_tag[s][w]    <= '0;
          r_btb_target[s][w] <= '0;
          r_btb_type[s][w]   <= '0;
        end
      end
      for (int i = 0; i < int'(BHT_NUM); i++) r_bht[i] <= '0;
      for (int i = 0; i < int'(PHT_NUM); i++) r_pht[i] <= 2'b01;
      for (int i = 0; i < int'(RAS_DEPTH); i++) r_ras[i] <= '0;
    end else begin
      pred_valid <= fetch_valid;
      if (fetch_valid) begin
        pred_taken   <= w_win;
        pred_slot    <= w_win_slot;
        pred_target  <= w_win_target;
        pred_ras_ptr <= r_ras_ptr;
      end
      if (upd_valid && (upd_type == TYPE_COND)) begin
        if (upd_taken && (r_pht[w_upd_pht_idx] != 2'b11))
          r_pht[w_upd_pht_idx] <= r_pht[w_upd_pht_idx] + 2'd1;
        else if (!upd_taken && (r_pht[w_upd_pht_idx] != 2'b00))
          r_pht[w_upd_pht_idx] <= r_pht[w_upd_pht_idx] - 2'd1;
        r_bht[w_upd_bht_idx] <= {r_bht[w_upd_bht_idx][BHRLEN-2:0], upd_taken};
      end
      if (upd_valid && upd_taken) begin
        r_btb_valid[w_upd_set][w_upd_way]  <= 1'b1;
        r_btb_tag[w_upd_set][w_upd_way]    <= w_upd_tag;
        r_btb_target[w_upd_set][w_upd_way] <= upd_target;
        r_btb_type[w_upd_set][w_upd_way]   <= upd_type;
        if (w_upd_repl)
          r_rr[w_upd_set] <= WAY_W'((32'(r_rr[w_upd_set]) + 32'd1) % BTB_WAYS);
      end
      r_ras_ptr <= w_ras_ptr_nxt;
      if (w_ras_we) r_ras[w_ras_widx] <= w_ras_wdata;
    end
  end

endmodule

// File: tb/tb_bpu_ras_multi.sv
// Bench for bpu_ras_multi: directed scenarios plus random traffic, all outputs checked
// every cycle against a table/queue-level reference model of the predictor.
module tb_bpu_ras_multi;
  localparam int FW = 2, SETS = 16, WAYS = 2, RD = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid, pred_taken;
  logic [0:0]  pred_slot;
  logic [31:0] pred_target;
  logic [2:0]  pred_ras_ptr;
  logic        upd_valid, upd_taken, upd_mispred;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_type;
  logic [2:0]  upd_ras_ptr;

  bpu_ras_multi dut (
    .clk(clk), .resetn(resetn), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_slot(pred_slot),
    .pred_target(pred_target), .pred_ras_ptr(pred_ras_ptr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .upd_ras_ptr(upd_ras_ptr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state
  bit          m_val [SETS][WAYS];
  int          m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_typ [SETS][WAYS];
  int          m_rr  [SETS];
  int          m_bht [32];
  int          m_pht [64];
  logic [31:0] m_ras [RD];
  int          m_ptr;
  bit          e_valid, e_taken;
  int          e_slot, e_ptr;
  logic [31:0] e_target;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_val[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_typ[s][w] = 0;
      end
    end
    for (int i = 0; i < 32; i++) m_bht[i] = 0;
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    for (int i = 0; i < RD; i++) m_ras[i] = 0;
    m_ptr = 0;
    e_valid = 0; e_taken = 0; e_slot = 0; e_ptr = 0; e_target = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit tk, output int slot,
                                   output logic [31:0] tgt, output int typ, output logic [31:0] wpc);
    tk = 0; slot = 0; tgt = 0; typ = 0; wpc = 0;
    for (int k = 0; k < FW; k++) begin
      logic [31:0] p;
      int s, t;
      p = pc + 32'(4 * k);
      s = int'((p >> 2) % SETS);
      t = int'((p >> 6) % 256);
      for (int w = 0; w < WAYS; w++) begin
        if (!tk && m_val[s][w] && m_tag[s][w] == t &&
            (m_typ[s][w] != 0 || m_pht[m_bht[int'((p >> 2) % 32)] ^ int'((p >> 2) % 64)] >= 2)) begin
          tk = 1; slot = k; typ = m_typ[s][w]; wpc = p;
          tgt = (typ == 3) ? m_ras[(m_ptr + RD - 1) % RD] : m_tgt[s][w];
        end
      end
    end
  endfunction

  function automatic void m_train(input logic [31:0] pc, input int ty, input bit tk, input logic [31:0] tg);
    int s, t, bi, pi, way;
    if (ty == 0) begin
      bi = int'((pc >> 2) % 32);
      pi = m_bht[bi] ^ int'((pc >> 2) % 64);
      if (tk) m_pht[pi] = (m_pht[pi] < 3) ? m_pht[pi] + 1 : 3;
      else    m_pht[pi] = (m_pht[pi] > 0) ? m_pht[pi] - 1 : 0;
      m_bht[bi] = (m_bht[bi] * 2 + int'(tk)) % 64;
    end
    if (tk) begin
      s = int'((pc >> 2) % SETS);
      t = int'((pc >> 6) % 256);
      way = -1;
      for (int w = 0; w < WAYS; w++) if (way < 0 && m_val[s][w] && m_tag[s][w] == t) way = w;
      for (int w = 0; w < WAYS; w++) if (way < 0 && !m_val[s][w]) way = w;
      if (way < 0) begin
        way = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_val[s][way] = 1; m_tag[s][way] = t; m_tgt[s][way] = tg; m_typ[s][way] = ty;
    end
  endfunction

  function automatic void m_stack(input bit win, input int wty, input logic [31:0] wpc,
                                  input bit mis, input int uty, input logic [31:0] upc, input int uptr);
    if (mis) begin
      m_ptr = uptr;
      if (uty == 2) begin m_ras[m_ptr] = upc + 4; m_ptr = (m_ptr + 1) % RD; end
      else if (uty == 3) m_ptr = (m_ptr + RD - 1) % RD;
    end else if (win) begin
      if (wty == 2) begin m_ras[m_ptr] = wpc + 4; m_ptr = (m_ptr + 1) % RD; end
      else if (wty == 3) m_ptr = (m_ptr + RD - 1) % RD;
    end
  endfunction

  // Single compare point: every output against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pred_valid",   32'(pred_valid),   32'(e_valid));
      chk("pred_taken",   32'(pred_taken),   32'(e_taken));
      chk("pred_slot",    32'(pred_slot),    32'(e_slot));
      chk("pred_target",  pred_target,       e_target);
      chk("pred_ras_ptr", 32'(pred_ras_ptr), 32'(e_ptr));
    end
  end

  task automatic step(input bit fv, input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                      input logic [1:0] ut, input bit utk, input logic [31:0] utg,
                      input bit umis, input int uptr);
    bit tk; int sl, ty; logic [31:0] tg, wpc;
    bit n_valid, n_taken; int n_slot, n_ptr; logic [31:0] n_target;
    fetch_valid = fv; fetch_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_type = ut; upd_taken = utk; upd_target = utg;
    upd_mispred = umis; upd_ras_ptr = 3'(uptr);
    m_lookup(fpc, tk, sl, tg, ty, wpc);
    n_valid = fv; n_taken = e_taken; n_slot = e_slot; n_target = e_target; n_ptr = e_ptr;
    if (fv) begin n_taken = tk; n_slot = sl; n_target = tg; n_ptr = m_ptr; end
    if (uv) m_train(upc, int'(ut), utk, utg);
    m_stack(fv && tk, ty, wpc, uv && umis, int'(ut), upc, uptr);
    @(posedge clk);
    e_valid = n_valid; e_taken = n_taken; e_slot = n_slot; e_target = n_target; e_ptr = n_ptr;
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1, pc, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [1:0] ty, input bit tk, input logic [31:0] tg);
    step(0, 0, 1, pc, ty, tk, tg, 0, 0);
  endtask

  // Reset asserted mid-cycle while a lookup is in flight; that lookup must be dropped.
  task automatic do_reset();
    fetch_valid = 1; fetch_pc = 32'h1c000004; upd_valid = 0; upd_mispred = 0;
    #2 resetn = 0;
    m_reset();
    fetch_valid = 0;
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    @(posedge clk); #1;
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
  endtask

  task automatic lit(input string nm, input bit tk, input int sl, input logic [31:0] tg);
    chk({nm, "_taken"},  32'(pred_taken), 32'(tk));
    chk({nm, "_slot"},   32'(pred_slot),  32'(sl));
    chk({nm, "_target"}, pred_target,     tg);
  endtask

  initial begin
    resetn = 0; fetch_valid = 0; fetch_pc = 0; upd_valid = 0; upd_pc = 0; upd_type = 0;
    upd_taken = 0; upd_target = 0; upd_mispred = 0; upd_ras_ptr = 0;
    m_reset();
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    @(posedge clk); #1;
    chk("t1_pred_valid", 32'(pred_valid), 32'd0);
    fetch(32'h1c000000);
    chk("t1_valid", 32'(pred_valid), 32'd1);
    lit("t1", 0, 0, 32'h0);

    // BTB allocate/hit, and same-cycle write is invisible to the concurrent lookup
    train(32'h1c000004, 2'b01, 1, 32'h1c000100);
    fetch(32'h1c000000);
    lit("t2", 1, 1, 32'h1c000100);
    step(1, 32'h1c000040, 1, 32'h1c000040, 2'b01, 1, 32'h1c000200, 0, 0);
    lit("t2_coll", 0, 0, 32'h0);
    fetch(32'h1c000040);
    lit("t2_after", 1, 0, 32'h1c000200);

    // PHT with local history: saturating counters
    do_reset();
    repeat (8) train(32'h80, 2'b00, 1, 32'h200);
    fetch(32'h80);
    lit("t3_taken", 1, 0, 32'h200);
    repeat (2) train(32'h80, 2'b00, 0, 32'h0);
    fetch(32'h80);
    lit("t3_nt2", 0, 0, 32'h0);
    repeat (8) train(32'h80, 2'b00, 0, 32'h0);
    fetch(32'h80);
    lit("t3_hold00", 0, 0, 32'h0);

    // Round-robin replacement in set 0
    do_reset();
    train(32'h000, 2'b01, 1, 32'h1000);
    train(32'h040, 2'b01, 1, 32'h2000);
    train(32'h080, 2'b01, 1, 32'h3000);
    fetch(32'h000);  lit("t4_evict0", 0, 0, 32'h0);
    fetch(32'h040);  lit("t4_keep1", 1, 0, 32'h2000);
    train(32'h0c0, 2'b01, 1, 32'h4000);
    fetch(32'h040);  lit("t4_evict1", 0, 0, 32'h0);
    fetch(32'h080);  lit("t4_keep", 1, 0, 32'h3000);
    train(32'h080, 2'b01, 1, 32'h3800);
    fetch(32'h080);  lit("t4_rewrite", 1, 0, 32'h3800);
    fetch(32'h0c0);  lit("t4_noevict", 1, 0, 32'h4000);

    // RAS call/return and overflow
    do_reset();
    train(32'h100, 2'b10, 1, 32'h500);
    train(32'h53c, 2'b11, 1, 32'h0);
    fetch(32'h100);  lit("t5_call", 1, 0, 32'h500);
    fetch(32'h53c);  lit("t5_ret", 1, 0, 32'h104);
    chk("t5_ret_ptr", 32'(pred_ras_ptr), 32'd1);
    for (int i = 0; i < 9; i++) train(32'h604 + 32'(4 * i), 2'b10, 1, 32'h900);
    for (int i = 0; i < 9; i++) fetch(32'h604 + 32'(4 * i));
    for (int i = 0; i < 9; i++) begin
      fetch(32'h53c);
      if (i == 0) lit("t5_ret1", 1, 0, 32'h628);
      if (i == 7) lit("t5_ret8", 1, 0, 32'h60c);
      if (i == 8) lit("t5_ret9_lost", 1, 0, 32'h628);
    end

    // Checkpoint restore and mispredict override of a same-cycle push/pop
    do_reset();
    for (int i = 0; i < 3; i++) train(32'h604 + 32'(4 * i), 2'b10, 1, 32'h900);
    train(32'h53c, 2'b11, 1, 32'h0);
    for (int i = 0; i < 3; i++) fetch(32'h604 + 32'(4 * i));
    fetch(32'h604);
    chk("t6_ckpt", 32'(pred_ras_ptr), 32'd3);
    fetch(32'h608);
    step(0, 0, 1, 32'h900, 2'b00, 0, 0, 1, 3);
    fetch(32'h53c);  lit("t6_restore", 1, 0, 32'h610);
    step(1, 32'h604, 1, 32'h700, 2'b10, 1, 32'h0, 1, 1);
    fetch(32'h53c);  lit("t6_mis_call", 1, 0, 32'h704);
    step(1, 32'h53c, 1, 32'h53c, 2'b11, 1, 32'h0, 1, 3);
    lit("t6_mis_ret_pred", 1, 0, 32'h608);
    fetch(32'h53c);  lit("t6_mis_ret", 1, 0, 32'h704);

    // Random traffic over a small address pool to force hits, conflicts and wraps
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ut;
      bit utk;
      ut  = 2'($urandom_range(0, 3));
      utk = (ut != 2'b00) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 255)) << 2,
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, ut, utk,
           $urandom & 32'hffff_fffc, $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)));
    end

    fetch_valid = 0; upd_valid = 0; upd_mispred = 0;
    @(negedge clk); #1;
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
